// File: rtl/des_pkg.sv
// des_pkg: tables and constants shared by the DES encrypt and decrypt datapaths.
// All index tables use FIPS 46 numbering: entry j (0-based) is the 1-based
// source bit for output bit j+1, where bit 1 is the most significant bit.
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [4:0] LAST_ROUND = 5'd16;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2, 60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6, 64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1, 59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5, 63, 55, 47, 39, 31, 23, 15,  7};

  localparam int FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32, 39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30, 37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28, 35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26, 33,  1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Right-rotate amount applied before round i (index i-1) on the decrypt side.
  // Round 1 uses C0/D0 directly because 28 encrypt shifts return to the start.
  localparam int ROT_R [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // S-boxes, entry [box][row*16 + col].
  localparam int S_T [8][64] = '{
    '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,  0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
       4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0, 15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
    '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,  3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
       0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15, 13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
    '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8, 13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
      13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,  1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
    '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15, 13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
      10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,  3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
    '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9, 14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
       4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14, 11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
    '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11, 10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
       9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,  4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
    '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1, 13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
       1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,  6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
    '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,  1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
       7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,  2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}};

endpackage

// File: rtl/des_f_function.sv
// des_f_function: DES round function f(R,K) = P(S(E(R) xor K)).
// Purely combinational; no latency, no handshake.
// Ports: i_r[32:1] right half, i_k[48:1] round subkey, o_f[32:1] result (bit 1 = MSB).
module des_f_function
  import des_pkg::*;
(
  input  logic [32:1] i_r,
  input  logic [48:1] i_k,
  output logic [32:1] o_f
);

  logic [48:1] w_e;
  logic [48:1] w_x;
  logic [32:1] w_s;

  // FIPS bit n of an N-bit vector sits at index N+1-n.
  for (genvar j = 1; j <= 48; j++) begin : g_e
    assign w_e[49-j] = i_r[33-E_T[j-1]];
  end

  assign w_x = w_e ^ i_k;

  // Row comes from the outer bits of each 6-bit group, column from the inner four.
  for (genvar s = 0; s < 8; s++) begin : g_sbox
    logic [5:0] w_six;
    assign w_six = w_x[48-6*s -: 6];
    assign w_s[32-4*s -: 4] = 4'(S_T[s][{w_six[5], w_six[0], w_six[4:1]}]);
  end

  for (genvar j = 1; j <= 32; j++) begin : g_p
    assign o_f[33-j] = w_s[33-P_T[j-1]];
  end

endmodule

// File: rtl/des_decrypt_iter.sv
// des_decrypt_iter: iterative DES decryption, one Feistel round per clock, subkeys K16..K1.
// Latency: OUT_VALID rises 16 cycles after the accept edge; one accept every 18 cycles at best.
// Backpressure: PLAIN_TEXT held in DONE until OUT_READY; IN_READY low outside IDLE.
// Ports: CLK/RST (sync, active high), CHIP_SELECT_BAR gate, IN_VALID/IN_READY with
// CIPHER_TEXT and KEY, OUT_VALID/OUT_READY with PLAIN_TEXT, BUSY while rounds run.
module des_decrypt_iter
  import des_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        CHIP_SELECT_BAR,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic [64:1] CIPHER_TEXT,
  input  logic [64:1] KEY,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [64:1] PLAIN_TEXT,
  output logic        BUSY
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [32:1] r_l;
  logic [32:1] r_r;
  logic [28:1] r_c;
  logic [28:1] r_d;
  logic [4:0]  r_cnt;

  logic        w_accept;
  logic [64:1] w_ip;
  logic [56:1] w_pc1;
  logic [3:0]  w_sched_idx;
  logic [1:0]  w_rot;
  logic [28:1] w_c_rot;
  logic [28:1] w_d_rot;
  logic [48:1] w_subkey;
  logic [32:1] w_f;
  logic [64:1] w_preout;
  logic [64:1] w_fp;
  logic        w_unused_parity;

  assign w_accept = (r_state == ST_IDLE) && IN_VALID && !CHIP_SELECT_BAR;

  // Input permutations, used only on the accept edge.
  for (genvar j = 1; j <= 64; j++) begin : g_ip
    assign w_ip[65-j] = CIPHER_TEXT[65-IP_T[j-1]];
  end

  for (genvar j = 1; j <= 56; j++) begin : g_pc1
    assign w_pc1[57-j] = KEY[65-PC1_T[j-1]];
  end

  // Parity bits 8,16,...,64 carry no key material.
  assign w_unused_parity = ^{KEY[57], KEY[49], KEY[41], KEY[33],
                             KEY[25], KEY[17], KEY[9],  KEY[1]};

  // Counter runs 1..16; the low nibble minus one maps 16 onto entry 15.
  assign w_sched_idx = r_cnt[3:0] - 4'd1;
  assign w_rot       = 2'(ROT_R[w_sched_idx]);

  // Undo the encrypt-side left shifts: a right rotate of the MSB-first halves.
  always_comb begin
    w_c_rot = r_c;
    w_d_rot = r_d;
    case (w_rot)
      2'd1: begin
        w_c_rot = {r_c[1], r_c[28:2]};
        w_d_rot = {r_d[1], r_d[28:2]};
      end
      2'd2: begin
        w_c_rot = {r_c[2:1], r_c[28:3]};
        w_d_rot = {r_d[2:1], r_d[28:3]};
      end
      default: ;
    endcase
  end

  // PC2 picks from the rotated halves directly; PC2 sources 1..28 live in C.
  for (genvar j = 1; j <= 48; j++) begin : g_pc2
    localparam int SRC = PC2_T[j-1];
    if (SRC <= 28) begin : g_c
      assign w_subkey[49-j] = w_c_rot[29-SRC];
    end else begin : g_d
      assign w_subkey[49-j] = w_d_rot[57-SRC];
    end
  end

  des_f_function u_f (
    .i_r (r_r),
    .i_k (w_subkey),
    .o_f (w_f)
  );

  // Final swap then FP.
  assign w_preout = {r_r, r_l};

  for (genvar j = 1; j <= 64; j++) begin : g_fp
    assign w_fp[65-j] = w_preout[65-FP_T[j-1]];
  end

  assign PLAIN_TEXT = OUT_VALID ? w_fp : '0;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    IN_READY    = 1'b0;
    OUT_VALID   = 1'b0;
    BUSY        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        IN_READY = 1'b1;
        if (w_accept) w_state_nxt = ST_ROUND;
      end
      ST_ROUND: begin
        BUSY = 1'b1;
        if (r_cnt == LAST_ROUND) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        OUT_VALID = 1'b1;
        if (OUT_READY) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_l   <= '0;
      r_r   <= '0;
      r_c   <= '0;
      r_d   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      {r_l, r_r} <= w_ip;
      {r_c, r_d} <= w_pc1;
      r_cnt      <= 5'd1;
    end else if (r_state == ST_ROUND) begin
      r_l <= r_r;
      r_r <= r_l ^ w_f;
      r_c <= w_c_rot;
      r_d <= w_d_rot;
      // Saturates so the DONE/IDLE counter value never wraps into a valid round.
      if (r_cnt != LAST_ROUND) r_cnt <= r_cnt + 5'd1;
    end
  end

endmodule
